// File: rtl/simple_spi_slave.sv
// SPI responder with an 8-bit Wishbone register file and small RX/TX FIFOs.
// SPI pins are oversampled in the clk_i domain; sck edges drive a four-state engine.
module simple_spi_slave #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cyc_i,
   input  logic       stb_i,
   input  logic [1:0] adr_i,
   input  logic       we_i,
   input  logic [7:0] dat_i,
   output logic [7:0] dat_o,
   output logic       ack_o,
   output logic       inta_o,
   input  logic       sck_i,
   input  logic       ss_ni,
   input  logic       mosi_i,
   output logic       miso_o,
   output logic       miso_oe_o,
   output logic [1:0] dbg_state_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
   logic r_sck_d, r_ss_d;
   logic w_sck, w_ss, w_mosi, w_ss_fall, w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;

   logic r_ack, r_ie, r_en, r_cpol, r_cpha;
   logic [7:0] r_dat;
   logic [3:0] r_flags;  // {IF, RXOR, TXUR, TXOV}
   logic [3:0] w_set, w_clr;
   logic [7:0] w_rdata;
   logic w_req, w_wr, w_rd, w_ctrl_wr, w_stat_wr, w_data_wr, w_data_rd, w_flush;

   logic [7:0] r_tx_mem [FIFO_DEPTH];
   logic [7:0] r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
   logic [CW-1:0] r_tx_cnt, r_rx_cnt;
   logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic w_tx_fetch, w_tx_pop, w_tx_push, w_rx_push_req, w_rx_push, w_rx_pop;
   logic [7:0] w_tx_byte;

   logic [1:0] r_state;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_rx_sh, r_tx_sh;
   logic r_miso;

   assign w_sck  = r_sck_sync[SYNC_STAGES-1];
   assign w_ss   = r_ss_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
   assign w_ss_fall = ~w_ss & r_ss_d;
   assign w_rise  = w_sck & ~r_sck_d;
   assign w_fall  = ~w_sck & r_sck_d;
   assign w_lead  = r_cpol ? w_fall : w_rise;
   assign w_trail = r_cpol ? w_rise : w_fall;
   assign w_sample = r_cpha ? w_trail : w_lead;
   assign w_shift  = r_cpha ? w_lead : w_trail;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_sck_sync  <= '0;
         r_ss_sync   <= '1;
         r_mosi_sync <= '0;
         r_sck_d     <= 1'b0;
         r_ss_d      <= 1'b1;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_ni};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
         r_sck_d     <= w_sck;
         r_ss_d      <= w_ss;
      end
   end

   // Bus accesses take effect on the edge that raises ack.
   assign w_req     = cyc_i & stb_i & ~r_ack;
   assign w_wr      = w_req & we_i;
   assign w_rd      = w_req & ~we_i;
   assign w_ctrl_wr = w_wr & (adr_i == 2'd0);
   assign w_stat_wr = w_wr & (adr_i == 2'd1);
   assign w_data_wr = w_wr & (adr_i == 2'd2);
   assign w_data_rd = w_rd & (adr_i == 2'd2);
   assign w_flush   = w_ctrl_wr & r_en & ~dat_i[6];

   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == FULL_CNT);
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == FULL_CNT);

   assign w_tx_fetch    = ((r_state == ST_LOAD) || (r_state == ST_DONE)) & r_en & ~w_flush;
   assign w_tx_pop      = w_tx_fetch & ~w_tx_empty;
   assign w_tx_push     = w_data_wr & (~w_tx_full | w_tx_pop);
   assign w_tx_byte     = w_tx_empty ? 8'hFF : r_tx_mem[r_tx_rd];
   assign w_rx_push_req = (r_state == ST_DONE) & r_en & ~w_flush;
   assign w_rx_pop      = w_data_rd & ~w_rx_empty;
   assign w_rx_push     = w_rx_push_req & (~w_rx_full | w_rx_pop);

   assign w_set = {w_rx_push_req, w_rx_push_req & ~w_rx_push,
                   w_tx_fetch & w_tx_empty, w_data_wr & ~w_tx_push};
   assign w_clr = w_stat_wr ? dat_i[7:4] : 4'h0;

   always_comb begin
      w_rdata = 8'h00;
      case (adr_i)
         2'd0:    w_rdata = {r_ie, r_en, 2'b00, r_cpol, r_cpha, 2'b00};
         2'd1:    w_rdata = {r_flags, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
         2'd2:    w_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
         default: w_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ack   <= 1'b0;
         r_dat   <= 8'h00;
         r_ie    <= 1'b0;
         r_en    <= 1'b0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_flags <= 4'h0;
      end else begin
         r_ack   <= w_req;
         r_flags <= (r_flags & ~w_clr) | w_set;
         if (w_rd) r_dat <= w_rdata;
         if (w_ctrl_wr) begin
            r_ie   <= dat_i[7];
            r_en   <= dat_i[6];
            r_cpol <= dat_i[3];
            r_cpha <= dat_i[2];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_tx_wr <= '0; r_tx_rd <= '0; r_tx_cnt <= '0;
         r_rx_wr <= '0; r_rx_rd <= '0; r_rx_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_tx_mem[i] <= 8'h00;
            r_rx_mem[i] <= 8'h00;
         end
      end else if (w_flush) begin
         r_tx_wr <= '0; r_tx_rd <= '0; r_tx_cnt <= '0;
         r_rx_wr <= '0; r_rx_rd <= '0; r_rx_cnt <= '0;
      end else begin
         if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= dat_i;
            r_tx_wr <= r_tx_wr + AW'(1);
         end
         if (w_tx_pop) r_tx_rd <= r_tx_rd + AW'(1);
         if (w_tx_push && !w_tx_pop) r_tx_cnt <= r_tx_cnt + CW'(1);
         else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - CW'(1);
         if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= r_rx_sh;
            r_rx_wr <= r_rx_wr + AW'(1);
         end
         if (w_rx_pop) r_rx_rd <= r_rx_rd + AW'(1);
         if (w_rx_push && !w_rx_pop) r_rx_cnt <= r_rx_cnt + CW'(1);
         else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CW'(1);
      end
   end

   // Deselect, disable or flush abandons any byte in flight and parks miso high.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= 3'd0;
         r_rx_sh   <= 8'h00;
         r_tx_sh   <= 8'h00;
         r_miso    <= 1'b1;
      end else if (!r_en || w_flush || (w_ss && (r_state != ST_IDLE))) begin
         r_state <= ST_IDLE;
         r_miso  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: if (w_ss_fall) r_state <= ST_LOAD;
            ST_LOAD: begin
               r_bit_cnt <= 3'd0;
               if (!r_cpha) begin
                  r_miso  <= w_tx_byte[7];
                  r_tx_sh <= {w_tx_byte[6:0], 1'b1};
               end else begin
                  r_tx_sh <= w_tx_byte;
               end
               r_state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (w_shift) begin
                  r_miso  <= r_tx_sh[7];
                  r_tx_sh <= {r_tx_sh[6:0], 1'b1};
               end
               if (w_sample) begin
                  r_rx_sh   <= {r_rx_sh[6:0], w_mosi};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= ST_DONE;
               end
            end
            default: begin
               r_tx_sh   <= w_tx_byte;
               r_bit_cnt <= 3'd0;
               r_state   <= ST_SHIFT;
            end
         endcase
      end
   end

   assign dat_o       = r_dat;
   assign ack_o       = r_ack;
   assign inta_o      = r_ie & r_flags[3];
   assign miso_o      = r_miso;
   assign miso_oe_o   = r_en & ~w_ss;
   assign dbg_state_o = r_state;
endmodule

// File: tb/tb_simple_spi_slave.sv
// Directed bench for simple_spi_slave: a bus master on Wishbone and a bit-banged SPI master.
module tb_simple_spi_slave;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [1:0] adr = 2'd0;
   logic [7:0] wdat = 8'h00;
   logic [7:0] rdat;
   logic       ack, inta;
   logic       sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
   logic       miso, miso_oe;
   logic [1:0] dbg_state;
   logic       m_cpol = 1'b0, m_cpha = 1'b0;
   int checks = 0;
   int errors = 0;

   simple_spi_slave dut (
      .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .adr_i(adr), .we_i(we),
      .dat_i(wdat), .dat_o(rdat), .ack_o(ack), .inta_o(inta), .sck_i(sck), .ss_ni(ss_n),
      .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic wait_half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic wb_access(input logic w, input logic [1:0] a, input logic [7:0] d,
                            output logic [7:0] q);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
      @(negedge clk);
      for (int k = 0; k < 4 && !ack; k++) @(negedge clk);
      if (!ack) begin
         checks++; errors++;
         $display("FAIL wb_ack_timeout: ack=%b required=1", ack);
      end
      q = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
      logic [7:0] q;
      wb_access(1'b1, a, d, q);
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [7:0] q);
      wb_access(1'b0, a, 8'h00, q);
   endtask

   // Shifts the top n bits of tx, MSB first, in the current master mode.
   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         if (!m_cpha) begin
            mosi = tx[i]; wait_half();
            sck = ~m_cpol; rx[i] = miso; wait_half();
            sck = m_cpol;
         end else begin
            sck = ~m_cpol; mosi = tx[i]; wait_half();
            sck = m_cpol; rx[i] = miso; wait_half();
         end
      end
   endtask

   task automatic select();
      ss_n = 1'b0;
      wait_half();
   endtask

   task automatic deselect();
      wait_half();
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic setup_mode(input logic cpol, input logic cpha);
      m_cpol = cpol; m_cpha = cpha; sck = cpol;
      wb_write(2'd0, 8'h00);
      wb_write(2'd1, 8'hF0);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] q;
      repeat (3) @(negedge clk);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got=%b exp=0", ack); end
      checks++; if (inta !== 1'b0) begin errors++; $display("FAIL rst_inta: got=%b exp=0", inta); end
      checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL rst_dat: got=%h exp=00", rdat); end
      checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rst_miso: got=%b exp=1", miso); end
      checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got=%b exp=0", miso_oe); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got=%0d exp=0", dbg_state); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      wb_read(2'd1, q);
      checks++; if (q !== 8'h05) begin errors++; $display("FAIL rst_stat: got=%h exp=05", q); end
      wb_read(2'd0, q);
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_ctrl: got=%h exp=00", q); end
      wb_write(2'd0, 8'hFF);
      wb_read(2'd0, q);
      checks++; if (q !== 8'hCC) begin errors++; $display("FAIL ctrl_mask: got=%h exp=cc", q); end
      wb_write(2'd0, 8'h00);
      wb_write(2'd3, 8'hFF);
      wb_read(2'd3, q);
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reserved: got=%h exp=00", q); end
   endtask

   task automatic test_mode(input logic cpol, input logic cpha);
      logic [7:0] q, rx;
      int m;
      m = {30'd0, cpol, cpha};
      setup_mode(cpol, cpha);
      wb_write(2'd2, 8'hA5);
      wb_write(2'd0, {2'b01, 2'b00, cpol, cpha, 2'b00});
      wb_read(2'd1, q);
      checks++; if ((q & 8'h81) !== 8'h01) begin errors++; $display("FAIL mode%0d_stat_pre: got=%h exp=01", m, q & 8'h81); end
      checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL mode%0d_oe_idle: got=%b exp=0", m, miso_oe); end
      select();
      checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL mode%0d_oe_sel: got=%b exp=1", m, miso_oe); end
      spi_bits(8'h3C, 8, rx);
      deselect();
      checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL mode%0d_miso: got=%h exp=a5", m, rx); end
      wb_read(2'd1, q);
      checks++; if ((q & 8'h81) !== 8'h80) begin errors++; $display("FAIL mode%0d_stat_post: got=%h exp=80", m, q & 8'h81); end
      wb_read(2'd2, q);
      checks++; if (q !== 8'h3C) begin errors++; $display("FAIL mode%0d_rx: got=%h exp=3c", m, q); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL mode%0d_state: got=%0d exp=0", m, dbg_state); end
   endtask

   task automatic test_burst();
      logic [7:0] q, rx;
      logic [7:0] exp_rx [5] = '{8'h11, 8'h22, 8'hFF, 8'hFF, 8'hFF};
      setup_mode(1'b0, 1'b0);
      wb_write(2'd0, 8'h40);
      wb_write(2'd2, 8'h11);
      wb_write(2'd2, 8'h22);
      select();
      for (int i = 0; i < 5; i++) begin
         spi_bits(8'hC1 + 8'(i), 8, rx);
         checks++; if (rx !== exp_rx[i]) begin errors++; $display("FAIL burst_miso%0d: got=%h exp=%h", i, rx, exp_rx[i]); end
      end
      deselect();
      wb_read(2'd1, q);
      checks++; if (q !== 8'hE6) begin errors++; $display("FAIL burst_stat: got=%h exp=e6", q); end
      for (int i = 0; i < 5; i++) begin
         wb_read(2'd2, q);
         checks++;
         if (q !== ((i < 4) ? 8'hC1 + 8'(i) : 8'h00)) begin
            errors++; $display("FAIL burst_rx%0d: got=%h exp=%h", i, q, (i < 4) ? 8'hC1 + 8'(i) : 8'h00);
         end
      end
      wb_read(2'd1, q);
      checks++; if (q !== 8'hE5) begin errors++; $display("FAIL burst_stat_drained: got=%h exp=e5", q); end
   endtask

   task automatic test_partial();
      logic [7:0] q, rx;
      setup_mode(1'b0, 1'b0);
      wb_write(2'd0, 8'h40);
      wb_write(2'd2, 8'h5A);
      select();
      spi_bits(8'hF0, 5, rx);
      deselect();
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL partial_state: got=%0d exp=0", dbg_state); end
      wb_read(2'd1, q);
      checks++; if ((q & 8'h81) !== 8'h01) begin errors++; $display("FAIL partial_stat: got=%h exp=01", q & 8'h81); end
      wb_write(2'd2, 8'h69);
      select();
      spi_bits(8'h96, 8, rx);
      deselect();
      checks++; if (rx !== 8'h69) begin errors++; $display("FAIL partial_next_miso: got=%h exp=69", rx); end
      wb_read(2'd2, q);
      checks++; if (q !== 8'h96) begin errors++; $display("FAIL partial_next_rx: got=%h exp=96", q); end
   endtask

   task automatic test_irq();
      logic [7:0] rx;
      setup_mode(1'b0, 1'b0);
      wb_write(2'd0, 8'hC0);
      checks++; if (inta !== 1'b0) begin errors++; $display("FAIL irq_pre: got=%b exp=0", inta); end
      select();
      spi_bits(8'h77, 8, rx);
      deselect();
      checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL irq_underrun_miso: got=%h exp=ff", rx); end
      checks++; if (inta !== 1'b1) begin errors++; $display("FAIL irq_set: got=%b exp=1", inta); end
      wb_write(2'd1, 8'h80);
      @(negedge clk);
      checks++; if (inta !== 1'b0) begin errors++; $display("FAIL irq_clear: got=%b exp=0", inta); end
   endtask

   task automatic test_txfull();
      logic [7:0] q, rx;
      logic [7:0] exp_rx [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
      setup_mode(1'b0, 1'b0);
      wb_write(2'd0, 8'h40);
      for (int i = 1; i <= 5; i++) wb_write(2'd2, 8'(i));
      wb_read(2'd1, q);
      checks++; if (q !== 8'h19) begin errors++; $display("FAIL txfull_stat: got=%h exp=19", q); end
      select();
      for (int i = 0; i < 5; i++) begin
         spi_bits(8'h00, 8, rx);
         checks++; if (rx !== exp_rx[i]) begin errors++; $display("FAIL txfull_miso%0d: got=%h exp=%h", i, rx, exp_rx[i]); end
      end
      deselect();
      wb_write(2'd0, 8'h00);
      wb_read(2'd1, q);
      checks++; if (q !== 8'hF5) begin errors++; $display("FAIL txfull_flush_stat: got=%h exp=f5", q); end
   endtask

   task automatic test_async_reset();
      logic [7:0] q, rx;
      setup_mode(1'b0, 1'b0);
      wb_write(2'd0, 8'h40);
      wb_write(2'd2, 8'h81);
      select();
      spi_bits(8'hAA, 3, rx);
      rst_n = 1'b0;
      #1;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL arst_state: got=%0d exp=0", dbg_state); end
      checks++; if (miso_oe !== 1'b0 || miso !== 1'b1) begin
         errors++; $display("FAIL arst_pins: got oe=%b miso=%b exp oe=0 miso=1", miso_oe, miso);
      end
      sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      wb_read(2'd1, q);
      checks++; if (q !== 8'h05) begin errors++; $display("FAIL arst_stat: got=%h exp=05", q); end
   endtask

   initial begin
      test_reset();
      test_mode(1'b0, 1'b0);
      test_mode(1'b0, 1'b1);
      test_mode(1'b1, 1'b0);
      test_mode(1'b1, 1'b1);
      test_burst();
      test_partial();
      test_irq();
      test_txfull();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
